// File: rtl/adder_tree_feeder_if.sv
// adder_tree_feeder_if: operand stream in, frame sum out; master drives operands and takes results
interface adder_tree_feeder_if #(
    parameter int ADDER_WIDTH = 13,
    parameter int SUM_W = 16
);
    logic in_valid;
    logic in_ready;
    logic [ADDER_WIDTH-1:0] in_data;
    logic res_valid;
    logic res_ready;
    logic [SUM_W-1:0] res_data;
    modport master (output in_valid, in_data, res_ready, input in_ready, res_valid, res_data);
    modport slave (input in_valid, in_data, res_ready, output in_ready, res_valid, res_data);
endinterface

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: gathers NUM_OPS operands for the adder tree, waits its latency, returns the sum.
// Define FEEDER_SELF_CHECK_EN to cross-check tree_sum against a local accumulator (err flag).
module adder_tree_feeder #(
    parameter int ADDER_WIDTH = 13,
    parameter int NUM_OPS = 8,
    parameter int TREE_LATENCY = 2,
    localparam int SUM_W = ADDER_WIDTH + $clog2(NUM_OPS)
) (
    input  logic clk,
    input  logic rst,
    adder_tree_feeder_if.slave s,
    output logic [NUM_OPS*ADDER_WIDTH-1:0] op_bus,
    input  logic [SUM_W-1:0] tree_sum,
    output logic err
);
    localparam int CW = $clog2(NUM_OPS);
    localparam int WW = $clog2(TREE_LATENCY + 2);
    typedef enum logic [1:0] {FILL, WAIT, HOLD} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wcnt;
    logic accept, last, capture, res_hs;
    assign s.in_ready = state == FILL && !rst;
    always_comb begin
        accept = s.in_valid && s.in_ready;
        last = accept && cnt == CW'(NUM_OPS - 1);
        capture = state == WAIT && wcnt == WW'(TREE_LATENCY);
        res_hs = s.res_valid && s.res_ready;
        state_n = last ? WAIT : capture ? HOLD : res_hs ? FILL : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            wcnt <= '0;
            op_bus <= '0;
            s.res_valid <= 1'b0;
            s.res_data <= '0;
        end else begin
            if (accept) begin
                op_bus[cnt*ADDER_WIDTH +: ADDER_WIDTH] <= s.in_data;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            wcnt <= state == WAIT ? wcnt + WW'(1) : '0;
            if (capture) begin
                s.res_data <= tree_sum;
                s.res_valid <= 1'b1;
            end
            if (res_hs) s.res_valid <= 1'b0;
        end
    end
`ifdef FEEDER_SELF_CHECK_EN
    logic [SUM_W-1:0] acc;
    // acc restarts whenever the FSM re-enters FILL (reset or result handshake)
    always_ff @(posedge clk) begin
        if (rst || res_hs) acc <= '0;
        else if (accept) acc <= acc + SUM_W'(s.in_data);
        if (rst) err <= 1'b0;
        else if (capture && tree_sum != acc) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_adder_tree_feeder.sv
// tb_adder_tree_feeder: directed frames against a two-stage registered tree model
module tb_adder_tree_feeder;
    logic clk = 1'b0;
    logic rst;
    logic [103:0] op_bus;
    logic [15:0] tree_sum = '0;
    logic [15:0] s1 = '0;
    logic [15:0] lsum;
    logic [15:0] bump = '0;
    logic err;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int e, e1, r;
    logic [15:0] held;
    logic [103:0] held_bus;

    adder_tree_feeder_if #(.ADDER_WIDTH(13), .SUM_W(16)) bus ();

    adder_tree_feeder dut (
        .clk(clk),
        .rst(rst),
        .s(bus.slave),
        .op_bus(op_bus),
        .tree_sum(tree_sum),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        lsum = '0;
        for (int k = 0; k < 8; k++) lsum = lsum + 16'(op_bus[k*13 +: 13]);
    end
    always @(posedge clk) begin
        s1 <= lsum;
        tree_sum <= s1 + bump;
    end

    function automatic logic [103:0] exp_bus(input int base, input int step);
        logic [103:0] v = '0;
        for (int k = 0; k < 8; k++) v[k*13 +: 13] = 13'(base + k * step);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int base, input int step, input bit gap, output int last_edge);
        int n;
        last_edge = 0;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 13'(base + k * step);
            n = 0;
            while (!bus.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n == 50) chk("in_ready_timeout", 128'(bus.in_ready), 128'(1));
            @(negedge clk);
            last_edge = cyc;
            if (gap && k < 7) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_res(output int seen);
        int n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        seen = cyc;
        chk("res_valid_seen", 128'(bus.res_valid), 128'(1));
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_res_valid", 128'(bus.res_valid), 128'(0));
        chk("rst_res_data", 128'(bus.res_data), 128'(0));
        chk("rst_op_bus", 128'(op_bus), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("fill_in_ready", 128'(bus.in_ready), 128'(1));

        // frame of 1..8, continuous valid
        bus.res_ready = 1'b1;
        send_frame(1, 1, 1'b0, e);
        chk("t1_op_bus", 128'(op_bus), 128'(exp_bus(1, 1)));
        chk("t1_wait_in_ready", 128'(bus.in_ready), 128'(0));
        wait_res(r);
        chk("t1_latency", 128'(r - e), 128'(3));
        chk("t1_res_data", 128'(bus.res_data), 128'(36));
        chk("t1_err", 128'(err), 128'(0));
        @(negedge clk);
        chk("t1_res_dropped", 128'(bus.res_valid), 128'(0));
        chk("t1_in_ready_back", 128'(bus.in_ready), 128'(1));

        // full-scale operands
        send_frame(13'h1FFF, 0, 1'b0, e);
        wait_res(r);
        chk("t2_res_data", 128'(bus.res_data), 128'(16'hFFF8));
        @(negedge clk);

        // gapped valid, consumer stalls the result
        bus.res_ready = 1'b0;
        send_frame(10, 3, 1'b1, e);
        chk("t3_op_bus", 128'(op_bus), 128'(exp_bus(10, 3)));
        wait_res(r);
        chk("t3_latency", 128'(r - e), 128'(3));
        chk("t3_res_data", 128'(bus.res_data), 128'(164));
        held = bus.res_data;
        held_bus = op_bus;
        bus.in_valid = 1'b1;
        bus.in_data = 13'h777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 128'(bus.res_valid), 128'(1));
            chk("t3_hold_data", 128'(bus.res_data), 128'(held));
            chk("t3_hold_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("t3_res_dropped", 128'(bus.res_valid), 128'(0));
        chk("t3_in_ready_back", 128'(bus.in_ready), 128'(1));
        chk("t3_op_bus_kept", 128'(op_bus), 128'(held_bus));

        // reset mid-frame
        bus.in_valid = 1'b1;
        bus.in_data = 13'd4;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_op_bus", 128'(op_bus), 128'(0));
        chk("t4_rst_in_ready", 128'(bus.in_ready), 128'(0));
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_no_result", 128'(bus.res_valid), 128'(0));
        send_frame(2, 0, 1'b0, e);
        wait_res(r);
        chk("t4_res_data", 128'(bus.res_data), 128'(16));
        chk("t4_latency", 128'(r - e), 128'(3));
        @(negedge clk);

        // back-to-back frames
        send_frame(1, 1, 1'b0, e1);
        wait_res(r);
        chk("t5_res_a", 128'(bus.res_data), 128'(36));
        chk("t5_hold_in_ready", 128'(bus.in_ready), 128'(0));
        send_frame(9, 1, 1'b0, e);
        chk("t5_period", 128'(e - e1), 128'(12));
        wait_res(r);
        chk("t5_res_b", 128'(bus.res_data), 128'(100));
        @(negedge clk);

        // tree returns a wrong sum once
        bump = 16'd1;
        send_frame(1, 1, 1'b0, e);
        wait_res(r);
        bump = 16'd0;
        chk("t6_res_tree_value", 128'(bus.res_data), 128'(37));
`ifdef FEEDER_SELF_CHECK_EN
        chk("t6_err_set", 128'(err), 128'(1));
`else
        chk("t6_err_tied", 128'(err), 128'(0));
`endif
        @(negedge clk);
        send_frame(9, 1, 1'b0, e);
        wait_res(r);
        chk("t6_res_ok", 128'(bus.res_data), 128'(100));
`ifdef FEEDER_SELF_CHECK_EN
        chk("t6_err_sticky", 128'(err), 128'(1));
`else
        chk("t6_err_still_tied", 128'(err), 128'(0));
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_err_cleared", 128'(err), 128'(0));
        chk("t6_res_cleared", 128'(bus.res_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
